ws2811_frame_sequencer: RTL

WS2811_FRAME_SEQUENCER -- requirements
Module: ws2811_frame_sequencer

---
 rtl/ws2811_pkg.sv | 16 +
 rtl/ws2811_latch_timer.sv | 36 +++
 rtl/ws2811_frame_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 frame sequencer.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    localparam int BYTES_PER_LED        = 3;
    localparam int BITS_PER_BYTE        = 8;
    localparam int DEFAULT_LATCH_CYCLES = 3000;

endpackage

// File: rtl/ws2811_latch_timer.sv
// Down-counter for the idle-low latch gap: load starts it, expire is high on
// the last cycle of the gap, exactly CYCLES cycles after the load edge.
module ws2811_latch_timer
    import ws2811_pkg::*;
#(
    parameter int CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= CNT_W'(CYCLES - 1);
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0)
                active <= 1'b0;
            else
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Streams pixel RAM bytes (address 0 upward, MSB first) to a WS2811 bit encoder,
// then holds the line idle for the latch gap. Define WS2811_LOOP_EN for continuous refresh.
module ws2811_frame_sequencer
    import ws2811_pkg::*;
#(
    parameter int NUM_LEDS     = 50,
    parameter int ADDR_W       = 12,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic              pwm_bit,
    output logic              pwm_valid,
    input  logic              pwm_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int                TOTAL_BYTES = BYTES_PER_LED * NUM_LEDS;
    localparam logic [ADDR_W-1:0] LAST_BYTE   = ADDR_W'(TOTAL_BYTES - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(BITS_PER_BYTE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] byte_idx;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              xfer;
    logic              byte_end;
    logic              last_byte;
    logic              latch_load;
    logic              latch_expire;
    logic              loop_again;

    assign xfer       = pwm_valid && pwm_ready;
    assign byte_end   = xfer && (bit_cnt == LAST_BIT);
    assign last_byte  = (byte_idx >= LAST_BYTE);
    assign latch_load = (state_nxt == ST_LATCH) && (state != ST_LATCH);

`ifdef WS2811_LOOP_EN
    // An abort seen anywhere in the frame lets the current latch gap finish, then stops.
    logic abort_pend;

    always_ff @(posedge clk) begin
        if (!rst_n)
            abort_pend <= 1'b0;
        else if (state == ST_IDLE)
            abort_pend <= 1'b0;
        else if (abort)
            abort_pend <= 1'b1;
    end

    assign loop_again = !abort_pend && !abort;
`else
    assign loop_again = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && !abort) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = abort ? ST_LATCH : ST_LOAD;
            ST_LOAD:  state_nxt = abort ? ST_LATCH : ST_SHIFT;
            ST_SHIFT: begin
                if (abort)
                    state_nxt = ST_LATCH;
                else if (byte_end)
                    state_nxt = last_byte ? ST_LATCH : ST_FETCH;
            end
            ST_LATCH: if (latch_expire) state_nxt = loop_again ? ST_FETCH : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pwm_valid  = (state == ST_SHIFT);
        pwm_bit    = (state == ST_SHIFT) ? shreg[7] : 1'b0;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_LATCH) && latch_expire;
        ram_addr   = byte_idx;
    end

    // Byte index stays on the last byte through the gap and rewinds as the gap ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_LOAD: bit_cnt <= '0;
                ST_SHIFT: begin
                    if (xfer && !abort) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_end && !last_byte)
                            byte_idx <= byte_idx + ADDR_W'(1);
                    end
                end
                ST_LATCH: if (latch_expire) byte_idx <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOAD)
            shreg <= ram_data;
        else if (state == ST_SHIFT && xfer)
            shreg <= {shreg[6:0], 1'b0};
    end

    ws2811_latch_timer #(
        .CYCLES(LATCH_CYCLES)
    ) u_latch_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (latch_load),
        .expire(latch_expire)
    );

endmodule
